// File: rtl/icache_fetch_responder.sv
// Fetch-side I-cache responder: direct-mapped, blocking, one-beat line refill.
// A lookup issued in cycle N returns per-slot hit flags and instructions in N+1.
// A slot-0 miss starts a refill; fetch re-issues the address once the line lands.

// Per-slot extraction: picks word (offset+SLOT) from the looked-up line and
// reports a hit only when that word still lies inside the line.
module icache_fetch_slot #(
    parameter int SLOT       = 0,
    parameter int LINE_WORDS = 4,
    parameter int OFF_BITS   = 2
) (
    input  logic                      lineHit_i,
    input  logic [OFF_BITS-1:0]       off_i,
    input  logic [LINE_WORDS*32-1:0]  lineData_i,
    output logic                      hit_o,
    output logic [31:0]               word_o
);
    logic [OFF_BITS:0]   pos;
    logic [OFF_BITS-1:0] wsel;

    // Word position past the head; wraps for out-of-line slots whose data is don't-care
    always_comb begin
        pos    = {1'b0, off_i} + (OFF_BITS+1)'(SLOT);
        wsel   = off_i + OFF_BITS'(SLOT);
        hit_o  = lineHit_i && (pos < (OFF_BITS+1)'(LINE_WORDS));
        word_o = lineData_i[wsel*32 +: 32];
    end
endmodule

module icache_fetch_responder #(
    parameter int FETCH_WIDTH = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int INDEX_BITS  = 6,
    parameter int LINE_WORDS  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        icRE,
    input  logic [ADDR_WIDTH-1:0]       icReadAddrIn,
    output logic [FETCH_WIDTH-1:0]      icReadHit,
    output logic [FETCH_WIDTH*32-1:0]   icReadDataOut,
    output logic                        memReq,
    output logic [ADDR_WIDTH-1:0]       memReqAddr,
    input  logic                        memReqReady,
    input  logic                        memRespValid,
    input  logic [LINE_WORDS*32-1:0]    memRespData,
    input  logic                        flush,
    output logic                        flushDone
);
    localparam int OFF_BITS  = $clog2(LINE_WORDS);
    localparam int LO        = OFF_BITS + 2;
    localparam int TAG_BITS  = ADDR_WIDTH - INDEX_BITS - LO;
    localparam int NUM_LINES = 1 << INDEX_BITS;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_FILL, S_WAIT_DISCARD} state_e;
    state_e state_q, state_d;

    logic [NUM_LINES-1:0]      valid_q;
    logic [TAG_BITS-1:0]       tagArr  [NUM_LINES];
    logic [LINE_WORDS*32-1:0]  dataArr [NUM_LINES];

    logic                         lkValid_q, lkFlushed_q;
    logic [ADDR_WIDTH-LO-1:0]     lkLine_q;
    logic [FETCH_WIDTH-1:0]       hit_q;
    logic [FETCH_WIDTH*32-1:0]    data_q;
    logic [ADDR_WIDTH-1:0]        memReqAddr_q;
    logic                         flushDone_q;

    logic [INDEX_BITS-1:0]        rdIdx, fillIdx;
    logic [OFF_BITS-1:0]          rdOff;
    logic [TAG_BITS-1:0]          rdTag, fillTag;
    logic                         lineHit, lookupAcc, missStart, fill;
    logic [FETCH_WIDTH-1:0]       slotHit;
    logic [FETCH_WIDTH*32-1:0]    slotWord;

    // Address split of the incoming lookup and of the held refill address
    always_comb begin
        rdOff     = icReadAddrIn[2 +: OFF_BITS];
        rdIdx     = icReadAddrIn[LO +: INDEX_BITS];
        rdTag     = icReadAddrIn[ADDR_WIDTH-1 -: TAG_BITS];
        fillIdx   = memReqAddr_q[LO +: INDEX_BITS];
        fillTag   = memReqAddr_q[ADDR_WIDTH-1 -: TAG_BITS];
        lookupAcc = icRE && (state_q == S_IDLE);
        lineHit   = valid_q[rdIdx] && (tagArr[rdIdx] == rdTag);
        // A flushed or already-blocked lookup never starts a refill
        missStart = lkValid_q && !hit_q[0] && !lkFlushed_q && !flush && (state_q == S_IDLE);
    end

    for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_slot
        icache_fetch_slot #(.SLOT(i), .LINE_WORDS(LINE_WORDS), .OFF_BITS(OFF_BITS)) u_slot (
            .lineHit_i  (lineHit),
            .off_i      (rdOff),
            .lineData_i (dataArr[rdIdx]),
            .hit_o      (slotHit[i]),
            .word_o     (slotWord[i*32 +: 32])
        );
    end

    // Register the lookup result; a lookup coinciding with flush is forced to miss
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lkValid_q   <= 1'b0;
            lkFlushed_q <= 1'b0;
            lkLine_q    <= '0;
            hit_q       <= '0;
            data_q      <= '0;
        end else begin
            lkValid_q   <= lookupAcc;
            lkFlushed_q <= flush;
            hit_q       <= (lookupAcc && !flush) ? slotHit : '0;
            if (lookupAcc) begin
                lkLine_q <= icReadAddrIn[ADDR_WIDTH-1:LO];
                data_q   <= slotWord;
            end
        end
    end

    // Refill address capture and flush acknowledge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            memReqAddr_q <= '0;
            flushDone_q  <= 1'b0;
        end else begin
            flushDone_q <= flush;
            if (missStart) memReqAddr_q <= {lkLine_q, {LO{1'b0}}};
        end
    end

    // Valid bits: flush clears everything, a completed refill sets its line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      valid_q <= '0;
        else if (flush) valid_q <= '0;
        else if (fill)  valid_q[fillIdx] <= 1'b1;
    end

    // Tag and data storage, written only by a refill
    always_ff @(posedge clk) begin
        if (fill) begin
            tagArr[fillIdx]  <= fillTag;
            dataArr[fillIdx] <= memRespData;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // FSM next state; flush always wins over a same-cycle response
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:         if (missStart) state_d = S_REQ;
            S_REQ:          if (memReqReady) state_d = flush ? S_WAIT_DISCARD : S_WAIT;
                            else if (flush)  state_d = S_IDLE;
            S_WAIT:         if (memRespValid) state_d = flush ? S_IDLE : S_FILL;
                            else if (flush)   state_d = S_WAIT_DISCARD;
            S_WAIT_DISCARD: if (memRespValid) state_d = S_IDLE;
            S_FILL:         state_d = S_IDLE;
            default:        state_d = S_IDLE;
        endcase
    end

    // FSM outputs; hits are suppressed whenever a refill is in progress
    always_comb begin
        memReq        = (state_q == S_REQ);
        memReqAddr    = memReqAddr_q;
        fill          = (state_q == S_WAIT) && memRespValid && !flush;
        icReadHit     = (state_q == S_IDLE) ? hit_q : '0;
        icReadDataOut = data_q;
        flushDone     = flushDone_q;
    end
endmodule

// File: tb/tb_icache_fetch_responder.sv
// Randomized + directed bench for icache_fetch_responder against a flag-based
// behavioural model of the cache contents and refill handshake.
module tb_icache_fetch_responder;
    localparam int FW = 2;
    localparam int LW = 4;

    logic         clk = 1'b0, rst = 1'b1, icRE = 1'b0;
    logic [31:0]  icReadAddrIn = '0;
    logic [1:0]   icReadHit;
    logic [63:0]  icReadDataOut;
    logic         memReq;
    logic [31:0]  memReqAddr;
    logic         memReqReady = 1'b0, memRespValid = 1'b0;
    logic [127:0] memRespData = '0;
    logic         flush = 1'b0, flushDone;

    always #5 clk = ~clk;

    icache_fetch_responder #(.FETCH_WIDTH(2), .ADDR_WIDTH(32), .INDEX_BITS(6), .LINE_WORDS(4)) dut (
        .clk(clk), .rst(rst), .icRE(icRE), .icReadAddrIn(icReadAddrIn),
        .icReadHit(icReadHit), .icReadDataOut(icReadDataOut),
        .memReq(memReq), .memReqAddr(memReqAddr), .memReqReady(memReqReady),
        .memRespValid(memRespValid), .memRespData(memRespData),
        .flush(flush), .flushDone(flushDone)
    );

    int checks = 0, errors = 0;

    // ---------------- behavioural model ----------------
    bit          mv[64];
    logic [21:0] mtag[64];
    logic [31:0] mdata[64][4];
    bit          req_out = 0, awaiting = 0, discard = 0, fill_cycle = 0;
    bit          lk_v = 0, lk_flushed = 0, exp_flushDone = 0;
    logic [31:0] lk_a = '0, req_addr = '0;
    logic [1:0]  exp_hit = '0;
    logic [31:0] exp_word[2] = '{32'h0, 32'h0};

    function automatic logic [31:0] memword(input logic [31:0] la, input int w);
        return (la - 32'h1000) * 3 + 32'(w) + 32'd1;
    endfunction

    function automatic logic [127:0] memline(input logic [31:0] la);
        logic [127:0] l;
        for (int w = 0; w < LW; w++) l[w*32 +: 32] = memword(la, w);
        return l;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) mv[i] = 0;
            req_out = 0; awaiting = 0; discard = 0; fill_cycle = 0;
            lk_v = 0; lk_flushed = 0; req_addr = '0; exp_hit = '0; exp_flushDone = 0;
        end else begin
            bit idle, start, acc;
            int ix, off;
            logic [1:0] nh;
            idle  = !(req_out || awaiting || fill_cycle);
            start = idle && lk_v && !lk_flushed && !flush && !exp_hit[0];
            acc   = idle && icRE;
            nh    = '0;
            if (acc && !flush) begin
                ix  = int'(icReadAddrIn[9:4]);
                off = int'(icReadAddrIn[3:2]);
                for (int i = 0; i < FW; i++)
                    if (mv[ix] && mtag[ix] == icReadAddrIn[31:10] && off + i < LW) begin
                        nh[i] = 1'b1;
                        exp_word[i] = mdata[ix][off + i];
                    end
            end
            if (fill_cycle) fill_cycle = 0;
            else if (req_out) begin
                if (memReqReady) begin req_out = 0; awaiting = 1; discard = flush; end
                else if (flush) req_out = 0;
            end else if (awaiting) begin
                if (memRespValid) begin
                    awaiting = 0;
                    if (!discard && !flush) begin
                        ix = int'(req_addr[9:4]);
                        mv[ix] = 1; mtag[ix] = req_addr[31:10];
                        for (int w = 0; w < LW; w++) mdata[ix][w] = memRespData[w*32 +: 32];
                        fill_cycle = 1;
                    end
                end else if (flush) discard = 1;
            end else if (start) begin
                req_out = 1; req_addr = {lk_a[31:4], 4'b0};
            end
            if (flush) for (int i = 0; i < 64; i++) mv[i] = 0;
            exp_flushDone = flush;
            lk_v = acc; lk_flushed = flush;
            if (acc) lk_a = icReadAddrIn;
            exp_hit = (req_out || awaiting || fill_cycle) ? 2'b00 : nh;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("icReadHit", 128'(icReadHit), 128'(exp_hit));
        chk("memReq", 128'(memReq), 128'(req_out));
        chk("memReqAddr", 128'(memReqAddr), 128'(req_addr));
        chk("flushDone", 128'(flushDone), 128'(exp_flushDone));
        for (int i = 0; i < FW; i++)
            if (exp_hit[i]) chk("slot data", 128'(icReadDataOut[i*32 +: 32]), 128'(exp_word[i]));
    endtask

    // ---------------- memory responder ----------------
    bit          mem_out = 0, flush_on_resp = 0;
    int          mem_cnt = 0, nr_left = 0, ready_pct = 100, resp_delay_max = 0, rand_flush_pct = 0;
    int          hs_count = 0, req_cycles = 0;
    logic [31:0] mem_addr = '0;

    task automatic mem_drive();
        memRespValid = 1'b0; memReqReady = 1'b0;
        flush = (rand_flush_pct > 0) && ($urandom_range(99) < rand_flush_pct);
        if (mem_out) begin
            if (mem_cnt == 0) begin
                memRespValid = 1'b1; memRespData = memline(mem_addr); mem_out = 0;
                if (flush_on_resp) flush = 1'b1;
            end else mem_cnt--;
        end else if (memReq) begin
            if (nr_left > 0) nr_left--;
            else if ($urandom_range(99) < ready_pct) begin
                memReqReady = 1'b1; mem_out = 1; mem_addr = memReqAddr; hs_count++;
                mem_cnt = (resp_delay_max > 0) ? int'($urandom_range(resp_delay_max)) : 0;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        if (memReq) req_cycles++;
        mem_drive();
    endtask

    task automatic fetch(input logic [31:0] a);
        icRE = 1'b1; icReadAddrIn = a;
        step();
        icRE = 1'b0;
    endtask

    task automatic settle();
        bit done = 0;
        step(); step();
        for (int n = 0; n < 200 && !done; n++) begin
            if (!(req_out || awaiting || fill_cycle) && !mem_out) done = 1;
            else step();
        end
        if (!done) chk("settle timeout", 128'(1), 128'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int hs0;
        bit seen;
        #2 rst = 1'b0;
        step(); step();
        chk("reset hit", 128'(icReadHit), 128'(0));
        chk("reset memReq", 128'(memReq), 128'(0));
        chk("reset memReqAddr", 128'(memReqAddr), 128'(0));
        chk("reset flushDone", 128'(flushDone), 128'(0));
        chk("reset data", 128'(icReadDataOut), 128'(0));
        rst = 1'b1;
        step();

        // cold miss then hit
        fetch(32'h1000);
        chk("cold miss hit", 128'(icReadHit), 128'(2'b00));
        step();
        chk("cold memReq", 128'(memReq), 128'(1));
        chk("cold memReqAddr", 128'(memReqAddr), 128'(32'h1000));
        settle();
        fetch(32'h1000);
        chk("refetch hit", 128'(icReadHit), 128'(2'b11));
        chk("refetch data", 128'(icReadDataOut), 128'(64'h00000002_00000001));

        // line-end boundary
        fetch(32'h100C);
        chk("line end hit", 128'(icReadHit), 128'(2'b01));
        chk("line end slot0", 128'(icReadDataOut[31:0]), 128'(32'h4));
        step(); step();
        chk("line end no req", 128'(memReq), 128'(0));

        // backpressure
        hs0 = hs_count; req_cycles = 0; nr_left = 5;
        fetch(32'h2000);
        settle();
        chk("backpressure handshakes", 128'(hs_count - hs0), 128'(1));
        chk("backpressure req cycles", 128'(req_cycles), 128'(6));
        fetch(32'h2000);
        chk("backpressure fill hit", 128'(icReadHit), 128'(2'b11));

        // conflict eviction
        fetch(32'h1400);
        settle();
        fetch(32'h1000);
        chk("evicted hit", 128'(icReadHit), 128'(2'b00));
        step();
        chk("evicted refill addr", 128'(memReqAddr), 128'(32'h1000));
        chk("evicted refill req", 128'(memReq), 128'(1));
        settle();

        // flush colliding with the response in WAIT
        flush_on_resp = 1; resp_delay_max = 2;
        fetch(32'h3000);
        seen = 0;
        for (int n = 0; n < 50 && !seen; n++) begin
            step();
            if (memRespValid && flush) seen = 1;
        end
        chk("flush+resp seen", 128'(seen), 128'(1));
        flush_on_resp = 0;
        step();
        chk("flushDone pulse", 128'(flushDone), 128'(1));
        step();
        chk("flushDone low", 128'(flushDone), 128'(0));
        settle();
        fetch(32'h3000);
        chk("post flush miss", 128'(icReadHit), 128'(2'b00));
        settle();
        fetch(32'h1000);
        chk("flush cleared old line", 128'(icReadHit), 128'(2'b00));
        settle();
        resp_delay_max = 0;

        // async reset while in REQ, then a stray response
        nr_left = 1000;
        fetch(32'h4000);
        step();
        chk("pre-reset memReq", 128'(memReq), 128'(1));
        #2 rst = 1'b0;
        #1;
        chk("async reset memReq", 128'(memReq), 128'(0));
        chk("async reset hit", 128'(icReadHit), 128'(0));
        nr_left = 0; mem_out = 1; mem_cnt = 1; mem_addr = 32'h4000;
        #3 rst = 1'b1;
        repeat (4) step();
        chk("stray resp no req", 128'(memReq), 128'(0));
        fetch(32'h4000);
        chk("post reset miss", 128'(icReadHit), 128'(2'b00));
        settle();
        fetch(32'h4000);
        chk("post reset refill hit", 128'(icReadHit), 128'(2'b11));

        // random traffic
        ready_pct = 60; resp_delay_max = 3; rand_flush_pct = 3;
        for (int n = 0; n < 3000; n++) begin
            icRE = ($urandom_range(99) < 70);
            icReadAddrIn = (32'($urandom_range(4, 7)) << 10) | (32'($urandom_range(3)) << 4)
                         | (32'($urandom_range(3)) << 2);
            step();
        end
        icRE = 1'b0; rand_flush_pct = 0;
        settle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/icache_fetch_responder.md
Name: icache_fetch_responder

Overview:
- Responder end of the fetch-stage I-cache read channel: fetch stage drives read enable and head physical address; this block returns per-slot hit flags and instructions.
- Direct-mapped, blocking, with a single-beat line refill FSM toward the memory side.
- Sits between FetchStage and the memory read port. Supports whole-cache invalidation for fence.i.

Parameters:
FETCH_WIDTH, 2, instructions returned per lookup (slots)
ADDR_WIDTH, 32, physical address width
INDEX_BITS, 6, log2 of line count (64 lines)
LINE_WORDS, 4, 32-bit instructions per line (power of two, >= FETCH_WIDTH)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
icRE  in  1  read enable from fetch stage
icReadAddrIn  in  ADDR_WIDTH  head fetch address, 4-byte aligned
icReadHit  out  FETCH_WIDTH  per-slot hit, valid for the lookup issued the previous cycle
icReadDataOut  out  FETCH_WIDTH*32  per-slot instruction; slot i at bits [32i+31:32i]
memReq  out  1  line refill request valid
memReqAddr  out  ADDR_WIDTH  line-aligned refill address
memReqReady  in  1  memory accepts request
memRespValid  in  1  refill data valid, one beat
memRespData  in  LINE_WORDS*32  full line, word 0 in LSBs
flush  in  1  invalidate all lines
flushDone  out  1  one-cycle pulse, cycle after invalidation

Behaviour:
- Address split: offset = addr[log2(LINE_WORDS)+1:2]; index = next INDEX_BITS; tag = remaining upper bits.
- Storage: data, tag, and valid per line. Valid bits are flops.
- Reset (rst=0, async): all valid bits=0; state=IDLE; icReadHit=0; memReq=0; memReqAddr=0; flushDone=0; icReadDataOut=0.
- Lookup latency is 1 cycle.
  - Cycle N: icRE=1 in IDLE registers the address and reads the line.
  - Cycle N+1: outputs reflect the hit/miss for that address.
  - icRE=0 in cycle N: all icReadHit=0 in N+1.
- Slot i hit = lineValid && tagMatch && (offset+i < LINE_WORDS). Slots past the line end report hit=0 and data don't-care.
- Slot 0 miss at N+1 (lookup valid, state IDLE, no flush) -> REQ at N+2 with memReqAddr = line-aligned miss address. All icReadHit=0 in every non-IDLE cycle.
- FSM states:
  - IDLE: lookups accepted.
  - REQ: memReq=1 and memReqAddr held stable until memReqReady=1 (handshake cycle). memReq drops the next cycle -> WAIT.
  - WAIT: on memRespValid, write data and tag, set valid -> FILL.
  - FILL: one cycle, no lookup accepted -> IDLE. Fetch re-issues the address; the hit appears 1 cycle after re-issue.
- icRE is ignored outside IDLE; no lookup is registered.
- Flush (any state):
  - All valid bits clear at the clock edge; flushDone=1 the next cycle.
  - REQ: memReq drops, -> WAIT_DISCARD.
  - WAIT: -> WAIT_DISCARD.
  - WAIT_DISCARD: the pending response is consumed and not written, then -> IDLE. Exception: if flush occurred in REQ before the handshake, there is no outstanding response, so go -> IDLE directly.
  - The pending lookup result in the cycle after flush is forced to miss, and no refill is started for it.
- Simultaneous memRespValid and flush in WAIT: flush wins. Line is not written, valid stays 0, -> IDLE.
- Fill and lookup of the same index never coincide; lookups are blocked outside IDLE.
- Reset asserted mid-refill: FSM to IDLE, memReq=0. A response arriving after reset release in IDLE is ignored.

Test Plan:
- Cold miss: reset, icRE=1 at addr 0x1000 -> icReadHit=00 next cycle; memReq=1 memReqAddr=0x1000; ready=1, resp line {0x4,0x3,0x2,0x1} -> re-issue 0x1000 gives hit=11, data slot0=0x1, slot1=0x2.
- Line-end boundary: after filling 0x1000, fetch 0x100C -> hit=01, slot0=0x4; no memReq raised.
- Backpressure: miss with memReqReady=0 for 5 cycles -> memReq and memReqAddr stable all 5 cycles; single handshake; one fill.
- Conflict eviction: fill 0x1000, then miss at 0x1400 (same index, different tag) refills. Fetch 0x1000 -> hit=00 and a new refill.
- Flush during WAIT: flush=1 with memRespValid=1 same cycle -> flushDone pulse next cycle; line not valid; re-fetch misses.
- Async reset in REQ: drop rst mid-cycle -> memReq=0 immediately; all hits 0 after release; stray memRespValid ignored.
